// File: rtl/mem_access_if.sv
// Execute-stage memory request plus data-memory bus bundle; the top keeps flat
// ports, so this bundle is wired to them by whoever instantiates it.
interface mem_access_if;
    logic        ex_valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] ExecResult;
    logic [31:0] r2;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic        done;
    logic [31:0] LoadData;
    logic        err;
    logic        timeout;

    // Handshake: dmem_req stays high with stable we/addr/wdata/be until the
    // cycle dmem_ack=1 (that cycle completes the access) or the wait limit.
    modport master (
        input  ex_valid, mem_read, mem_write, funct3, ExecResult, r2,
        input  dmem_ack, dmem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output stall, done, LoadData, err, timeout
    );

    modport slave (
        output ex_valid, mem_read, mem_write, funct3, ExecResult, r2,
        output dmem_ack, dmem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  stall, done, LoadData, err, timeout
    );
endinterface

// File: rtl/mem_access.sv
// Load/store unit: one outstanding data-memory access with lane steering,
// load formatting, alignment checking and a bounded wait for the ack.
module mem_access #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] ExecResult,
    input  logic [31:0] r2,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] LoadData,
    output logic        err,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    localparam logic [7:0] LP_LAST = 8'(MAX_WAIT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [7:0]  r_cnt;
    logic [31:0] r_load_data;
    logic        r_err;
    logic        r_timeout;

    logic        w_req;
    logic        w_bad;
    logic        w_misalign;
    logic        w_illegal;
    logic        w_expire;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_fmt;

    assign w_req      = ex_valid & (mem_read | mem_write);
    assign w_misalign = ((funct3[1:0] == 2'b01) & ExecResult[0]) |
                        ((funct3[1:0] == 2'b10) & (|ExecResult[1:0]));
    assign w_illegal  = mem_read ? (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
                                 : (funct3 > 3'b010);
    assign w_bad      = (mem_read & mem_write) | w_misalign | w_illegal;
    assign w_expire   = ~dmem_ack & (r_cnt == LP_LAST);

    // Store lanes are replicated so the memory only needs the byte enables.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = 32'd0;
        if (mem_write) begin
            case (funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << ExecResult[1:0];
                    w_wdata = {4{r2[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << {ExecResult[1], 1'b0};
                    w_wdata = {2{r2[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = r2;
                end
            endcase
        end
    end

    always_comb begin
        w_byte = dmem_rdata[8*r_off +: 8];
        w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_fmt = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_fmt = {{16{w_half[15]}}, w_half};
            3'b100:  w_fmt = {24'd0, w_byte};
            3'b101:  w_fmt = {16'd0, w_half};
            default: w_fmt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        stall        = 1'b0;
        done         = 1'b0;
        dmem_req     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    stall        = 1'b1;
                    w_next_state = w_bad ? DONE : BUSY;
                end
            end
            BUSY: begin
                stall    = 1'b1;
                dmem_req = 1'b1;
                if (dmem_ack || w_expire) w_next_state = DONE;
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_be        <= 4'd0;
            r_funct3    <= 3'd0;
            r_off       <= 2'd0;
            r_cnt       <= 8'd0;
            r_load_data <= 32'd0;
            r_err       <= 1'b0;
            r_timeout   <= 1'b0;
        end else if (r_state == IDLE && w_req) begin
            r_we     <= mem_write;
            r_addr   <= {ExecResult[31:2], 2'b00};
            r_wdata  <= w_wdata;
            r_be     <= w_be;
            r_funct3 <= funct3;
            r_off    <= ExecResult[1:0];
            r_cnt    <= 8'd0;
            if (w_bad) begin
                r_load_data <= 32'd0;
                r_err       <= 1'b1;
                r_timeout   <= 1'b0;
            end
        end else if (r_state == BUSY) begin
            // An ack on the last allowed cycle still counts as a completion.
            if (dmem_ack) begin
                r_load_data <= r_we ? 32'd0 : w_fmt;
                r_err       <= 1'b0;
                r_timeout   <= 1'b0;
            end else if (w_expire) begin
                r_load_data <= 32'd0;
                r_err       <= 1'b0;
                r_timeout   <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign dmem_we    = (r_state == BUSY) & r_we;
    assign dmem_addr  = (r_state == BUSY) ? r_addr  : 32'd0;
    assign dmem_wdata = (r_state == BUSY) ? r_wdata : 32'd0;
    assign dmem_be    = (r_state == BUSY) ? r_be    : 4'd0;
    assign LoadData   = r_load_data;
    assign err        = r_err;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access (MAX_WAIT=4): loads, stores, errors, timeout,
// ack-wins, ignored requests and reset abort.
module tb_mem_access;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mem_access_if bus();

    mem_access #(.MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (bus.ex_valid),
        .mem_read   (bus.mem_read),
        .mem_write  (bus.mem_write),
        .funct3     (bus.funct3),
        .ExecResult (bus.ExecResult),
        .r2         (bus.r2),
        .dmem_req   (bus.dmem_req),
        .dmem_we    (bus.dmem_we),
        .dmem_addr  (bus.dmem_addr),
        .dmem_wdata (bus.dmem_wdata),
        .dmem_be    (bus.dmem_be),
        .dmem_ack   (bus.dmem_ack),
        .dmem_rdata (bus.dmem_rdata),
        .stall      (bus.stall),
        .done       (bus.done),
        .LoadData   (bus.LoadData),
        .err        (bus.err),
        .timeout    (bus.timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data);
        bus.ex_valid   = 1'b1;
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.funct3     = f3;
        bus.ExecResult = addr;
        bus.r2         = data;
        #1;
    endtask

    task automatic idle_inputs();
        bus.ex_valid  = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.dmem_ack  = 1'b0;
    endtask

    // Load acked in its first BUSY cycle: done lands two edges after accept.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_ld);
        issue(1'b1, 1'b0, f3, addr, 32'd0);
        chk({tag, "_stall_acc"}, 32'(bus.stall), 32'd1);
        step();
        idle_inputs();
        #1;
        chk({tag, "_req"}, 32'(bus.dmem_req), 32'd1);
        chk({tag, "_addr"}, bus.dmem_addr, {addr[31:2], 2'b00});
        chk({tag, "_be"}, 32'(bus.dmem_be), 32'hF);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = rdata;
        step();
        bus.dmem_ack = 1'b0;
        #1;
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_data"}, bus.LoadData, exp_ld);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        step();
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.funct3     = 3'd0;
        bus.ExecResult = 32'd0;
        bus.r2         = 32'd0;
        bus.dmem_rdata = 32'd0;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_req", 32'(bus.dmem_req), 32'd0);
        chk("rst_we", 32'(bus.dmem_we), 32'd0);
        chk("rst_addr", bus.dmem_addr, 32'd0);
        chk("rst_wdata", bus.dmem_wdata, 32'd0);
        chk("rst_be", 32'(bus.dmem_be), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_ld", bus.LoadData, 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_to", 32'(bus.timeout), 32'd0);

        // Loads with all formatting variants
        do_load("lw", 3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
        chk("lw_hold", bus.LoadData, 32'hDEADBEEF);
        chk("lw_done_low", 32'(bus.done), 32'd0);
        do_load("lb", 3'b000, 32'h103, 32'h80112233, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 32'h103, 32'h80112233, 32'h00000080);
        do_load("lb1", 3'b000, 32'h101, 32'h80112233, 32'h00000022);
        do_load("lh", 3'b001, 32'h102, 32'h80112233, 32'hFFFF8011);
        do_load("lhu", 3'b101, 32'h100, 32'h1234F00D, 32'h0000F00D);

        // SH acked in the third BUSY cycle: stall for 4 cycles in total
        n = 0;
        issue(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD);
        if (bus.stall) n++;
        step();
        idle_inputs();
        #1;
        chk("sh_req", 32'(bus.dmem_req), 32'd1);
        chk("sh_we", 32'(bus.dmem_we), 32'd1);
        chk("sh_addr", bus.dmem_addr, 32'h200);
        chk("sh_be", 32'(bus.dmem_be), 32'hC);
        chk("sh_wdata", bus.dmem_wdata, 32'hABCDABCD);
        if (bus.stall) n++;
        step();
        chk("sh_be_stable", 32'(bus.dmem_be), 32'hC);
        if (bus.stall) n++;
        step();
        if (bus.stall) n++;
        bus.dmem_ack = 1'b1;
        step();
        bus.dmem_ack = 1'b0;
        #1;
        chk("sh_stall_cycles", 32'(n), 32'd4);
        chk("sh_done", 32'(bus.done), 32'd1);
        chk("sh_stall_done", 32'(bus.stall), 32'd0);
        chk("sh_ld", bus.LoadData, 32'd0);

        // Ignore ex_valid during DONE
        issue(1'b1, 1'b0, 3'b010, 32'h800, 32'd0);
        chk("done_ignore_stall", 32'(bus.stall), 32'd0);
        step();
        idle_inputs();
        #1;
        chk("done_ignore_idle", 32'(bus.stall), 32'd0);
        step();
        chk("done_ignore_req", 32'(bus.dmem_req), 32'd0);

        // SB and SW, acked immediately
        issue(1'b0, 1'b1, 3'b000, 32'h301, 32'h000000A5);
        step();
        idle_inputs();
        #1;
        chk("sb_be", 32'(bus.dmem_be), 32'h2);
        chk("sb_wdata", bus.dmem_wdata, 32'hA5A5A5A5);
        bus.dmem_ack = 1'b1;
        step();
        bus.dmem_ack = 1'b0;
        chk("sb_done", 32'(bus.done), 32'd1);
        step();
        issue(1'b0, 1'b1, 3'b010, 32'h400, 32'hCAFEF00D);
        step();
        idle_inputs();
        #1;
        chk("sw_be", 32'(bus.dmem_be), 32'hF);
        chk("sw_wdata", bus.dmem_wdata, 32'hCAFEF00D);
        bus.dmem_ack = 1'b1;
        step();
        bus.dmem_ack = 1'b0;
        chk("sw_done", 32'(bus.done), 32'd1);
        step();

        // Misaligned LW: no request, error completion
        issue(1'b1, 1'b0, 3'b010, 32'h101, 32'd0);
        chk("mis_req_acc", 32'(bus.dmem_req), 32'd0);
        step();
        idle_inputs();
        #1;
        chk("mis_req", 32'(bus.dmem_req), 32'd0);
        chk("mis_done", 32'(bus.done), 32'd1);
        chk("mis_err", 32'(bus.err), 32'd1);
        chk("mis_ld", bus.LoadData, 32'd0);
        step();

        // Illegal store funct3, illegal load funct3, both read and write
        issue(1'b0, 1'b1, 3'b011, 32'h0, 32'd0);
        step();
        idle_inputs();
        chk("ill_st_err", 32'({bus.done, bus.err, bus.dmem_req}), 32'b110);
        step();
        issue(1'b1, 1'b0, 3'b110, 32'h0, 32'd0);
        step();
        idle_inputs();
        chk("ill_ld_err", 32'({bus.done, bus.err, bus.dmem_req}), 32'b110);
        step();
        issue(1'b1, 1'b1, 3'b010, 32'h0, 32'd0);
        step();
        idle_inputs();
        chk("both_err", 32'({bus.done, bus.err, bus.dmem_req}), 32'b110);
        step();

        // ex_valid with neither read nor write, and a stray ack in IDLE
        issue(1'b0, 1'b0, 3'b010, 32'h0, 32'd0);
        chk("nop_stall", 32'(bus.stall), 32'd0);
        bus.dmem_ack = 1'b1;
        step();
        idle_inputs();
        #1;
        chk("nop_done", 32'(bus.done), 32'd0);
        chk("nop_req", 32'(bus.dmem_req), 32'd0);

        // Timeout: never acked, request held MAX_WAIT cycles
        issue(1'b1, 1'b0, 3'b010, 32'h500, 32'd0);
        step();
        idle_inputs();
        #1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (!bus.dmem_req) break;
            n++;
            step();
        end
        chk("to_req_cycles", 32'(n), 32'd4);
        chk("to_done", 32'(bus.done), 32'd1);
        chk("to_flag", 32'(bus.timeout), 32'd1);
        chk("to_ld", bus.LoadData, 32'd0);
        step();

        // Ack on the last allowed cycle wins over the timeout
        issue(1'b1, 1'b0, 3'b010, 32'h600, 32'd0);
        step();
        idle_inputs();
        step();
        step();
        step();
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'h11112222;
        #1;
        chk("aw_req", 32'(bus.dmem_req), 32'd1);
        step();
        bus.dmem_ack = 1'b0;
        #1;
        chk("aw_done", 32'(bus.done), 32'd1);
        chk("aw_to", 32'(bus.timeout), 32'd0);
        chk("aw_ld", bus.LoadData, 32'h11112222);
        step();

        // Reset in the second BUSY cycle aborts without done
        issue(1'b1, 1'b0, 3'b010, 32'h700, 32'd0);
        step();
        idle_inputs();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("abort_req", 32'(bus.dmem_req), 32'd0);
        chk("abort_stall", 32'(bus.stall), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        step();
        chk("abort_done2", 32'(bus.done), 32'd0);
        do_load("post_rst", 3'b010, 32'h104, 32'h55AA55AA, 32'h55AA55AA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
